mac_operand_streamer: RTL and testbench

Hardware producer for the MAC datapath: holds a small operand-pair memory and streams one dot-product vector into the MAC, driving its `a`, `b`, `valid_in` and accumulator-clear inputs. It replaces file-driven bench stimulus with on-chip sequencing. It sits directly upstream of the MAC, with `mac_clr` wired to the MAC's `reset`. A `done` pulse marks when the MAC's final `f` is valid.

---
 rtl/mac_operand_streamer_if.sv | 33 +++
 rtl/mac_operand_streamer.sv | 148 ++++++++++++++
 tb/tb_mac_operand_streamer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_streamer_if.sv
// Operand-streamer bus: memory write port, vector start/length, and the
// operand/valid/clear drive toward the MAC plus busy/done status.
interface mac_operand_streamer_if #(
  parameter int DEPTH = 16,
  parameter int W     = 14
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_a;
  logic [W-1:0]  wr_b;
  logic          start;
  logic [AW:0]   len;
  logic [W-1:0]  mac_a;
  logic [W-1:0]  mac_b;
  logic          mac_valid;
  logic          mac_clr;
  logic          busy;
  logic          done;

  // master: the controller loading pairs and launching vectors
  modport master (
    output wr_en, wr_addr, wr_a, wr_b, start, len,
    input  mac_a, mac_b, mac_valid, mac_clr, busy, done
  );

  // slave: the streamer itself
  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, start, len,
    output mac_a, mac_b, mac_valid, mac_clr, busy, done
  );
endinterface

// File: rtl/mac_operand_streamer.sv
// Streams one dot-product vector of stored operand pairs into the MAC.
// Optional MAC_STREAM_BUBBLE_EN inserts an idle cycle after every streamed pair.
module mac_operand_streamer #(
  parameter int DEPTH   = 16,
  parameter int W       = 14,
  parameter int MAC_LAT = 2
) (
  input logic                 clk,
  input logic                 reset,
  mac_operand_streamer_if.slave bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_N    = (AW+1)'(DEPTH);
  localparam logic [3:0]  DRAIN_INIT = (MAC_LAT >= 2) ? 4'(MAC_LAT - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, CLR, STREAM, DRAIN} state_t;

  state_t         state_reg;
  logic [2*W-1:0] mem [DEPTH];
  logic [AW:0]    len_reg;
  logic [AW:0]    idx_reg;
  logic [3:0]     cnt_reg;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           valid_reg;
  logic           clr_reg;
  logic           busy_reg;
  logic           done_reg;
`ifdef MAC_STREAM_BUBBLE_EN
  logic           bubble_reg;
`endif

  // Memory is only writable while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.wr_en)
      mem[bus.wr_addr] <= {bus.wr_a, bus.wr_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      valid_reg  <= 1'b0;
      clr_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef MAC_STREAM_BUBBLE_EN
      bubble_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      clr_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          // a start coinciding with done is dropped
          if (bus.start && !done_reg) begin
            len_reg   <= (bus.len > DEPTH_N) ? DEPTH_N : bus.len;
            clr_reg   <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= CLR;
          end
        end
        CLR: begin
          if (len_reg == '0) begin
            if (MAC_LAT == 1) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cnt_reg   <= DRAIN_INIT;
              state_reg <= DRAIN;
            end
          end else begin
            {a_reg, b_reg} <= mem[0];
            valid_reg      <= 1'b1;
            idx_reg        <= (AW+1)'(1);
            state_reg      <= STREAM;
`ifdef MAC_STREAM_BUBBLE_EN
            bubble_reg     <= 1'b0;
`endif
          end
        end
        STREAM: begin
`ifdef MAC_STREAM_BUBBLE_EN
          if (bubble_reg) begin
            {a_reg, b_reg} <= mem[idx_reg[AW-1:0]];
            valid_reg      <= 1'b1;
            idx_reg        <= idx_reg + 1'b1;
            bubble_reg     <= 1'b0;
          end else begin
            valid_reg <= 1'b0;
            if (idx_reg == len_reg) begin
              if (MAC_LAT == 1) begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end else begin
                cnt_reg   <= DRAIN_INIT;
                state_reg <= DRAIN;
              end
            end else begin
              bubble_reg <= 1'b1;
            end
          end
`else
          // idx_reg already points past the pair currently on the bus
          if (idx_reg == len_reg) begin
            valid_reg <= 1'b0;
            if (MAC_LAT == 1) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              cnt_reg   <= DRAIN_INIT;
              state_reg <= DRAIN;
            end
          end else begin
            {a_reg, b_reg} <= mem[idx_reg[AW-1:0]];
            valid_reg      <= 1'b1;
            idx_reg        <= idx_reg + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (cnt_reg == '0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mac_a     = a_reg;
  assign bus.mac_b     = b_reg;
  assign bus.mac_valid = valid_reg;
  assign bus.mac_clr   = clr_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_mac_operand_streamer.sv
// Self-checking bench: randomized vectors against a schedule/sum reference
// model and a behavioural MAC accumulator fed by the streamer outputs.
module tb_mac_operand_streamer;
  localparam int DEPTH   = 16;
  localparam int W       = 14;
  localparam int MAC_LAT = 2;
  localparam int AW      = $clog2(DEPTH);
`ifdef MAC_STREAM_BUBBLE_EN
  localparam int STRIDE  = 2;
`else
  localparam int STRIDE  = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_operand_streamer_if #(.DEPTH(DEPTH), .W(W)) bus ();

  mac_operand_streamer #(.DEPTH(DEPTH), .W(W), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     ref_a [DEPTH];
  int     ref_b [DEPTH];
  longint acc = 0;

  // Behavioural MAC: clear on mac_clr, accumulate every valid pair
  always @(posedge clk) begin
    if (bus.mac_clr)
      acc <= 0;
    else if (bus.mac_valid)
      acc <= acc + longint'($signed(bus.mac_a)) * longint'($signed(bus.mac_b));
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_a"}, longint'(bus.mac_a), 0);
    check_val({tag, "_b"}, longint'(bus.mac_b), 0);
    check_val({tag, "_valid"}, longint'(bus.mac_valid), 0);
    check_val({tag, "_clr"}, longint'(bus.mac_clr), 0);
    check_val({tag, "_busy"}, longint'(bus.busy), 0);
    check_val({tag, "_done"}, longint'(bus.done), 0);
  endtask

  function automatic longint exp_sum(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(ref_a[i]) * longint'(ref_b[i]);
    return s;
  endfunction

  function automatic int rnd_op();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic write_pair(input int addr, input int va, input int vb);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[AW-1:0];
    bus.wr_a    = va[W-1:0];
    bus.wr_b    = vb[W-1:0];
    ref_a[addr] = va;
    ref_b[addr] = vb;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Launch one vector and check every output cycle-by-cycle against the
  // schedule derived from len, stride and MAC latency.
  task automatic run_vec(input int ln, input int abort_k, input bit inject,
                         input bit restart_on_done, input bit do_wr,
                         input int wa, input int va, input int vb);
    int     n, done_k, beats, j;
    bit     ev;
    longint want;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = ln[AW:0];
    if (do_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = wa[AW-1:0];
      bus.wr_a    = va[W-1:0];
      bus.wr_b    = vb[W-1:0];
      ref_a[wa]   = va;
      ref_b[wa]   = vb;
    end
    n      = (ln > DEPTH) ? DEPTH : ln;
    done_k = (n == 0) ? 1 + MAC_LAT : 2 + STRIDE * (n - 1) + MAC_LAT;
    want   = exp_sum(n);
    beats  = 0;
    @(posedge clk);
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clk);
      if (k == 1 || (k == 4 && inject) || k == done_k + 1) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      ev = (n > 0) && (k >= 2) && ((k - 2) % STRIDE == 0) && ((k - 2) / STRIDE < n);
      check_val("clr", longint'(bus.mac_clr), longint'(k == 1));
      check_val("valid", longint'(bus.mac_valid), longint'(ev));
      check_val("busy", longint'(bus.busy), longint'(k < done_k));
      check_val("done", longint'(bus.done), longint'(k == done_k));
      if (n > 0 && k >= 2) begin
        j = (k - 2) / STRIDE;
        if (j > n - 1) j = n - 1;
        check_val("mac_a", longint'($signed(bus.mac_a)), longint'(ref_a[j]));
        check_val("mac_b", longint'($signed(bus.mac_b)), longint'(ref_b[j]));
      end
      if (k == done_k) check_val("f", acc, want);
      if (bus.mac_valid) beats++;
      if (k == abort_k) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_quiet("abort");
        for (int m = 0; m < n * STRIDE + MAC_LAT + 4; m++) begin
          @(negedge clk);
          check_val("abort_done", longint'(bus.done), 0);
          check_val("abort_busy", longint'(bus.busy), 0);
        end
        $display("run len=%0d aborted at T+%0d", ln, abort_k);
        return;
      end
      if (k == 3 && inject) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_a    = W'($urandom);
        bus.wr_b    = W'($urandom);
        bus.start   = 1'b1;
        bus.len     = (AW+1)'(1);
      end
      if (k == done_k && restart_on_done) begin
        bus.start = 1'b1;
        bus.len   = (AW+1)'(5);
      end
    end
    check_val("beats", longint'(beats), longint'(n));
    $display("run len=%0d pairs=%0d done_at=T+%0d f=%0d", ln, n, done_k, acc);
  endtask

  task automatic load_basic();
    write_pair(0, 3, 4);
    write_pair(1, -2, 5);
    write_pair(2, 7, -1);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_a = '0; bus.wr_b = '0;
    bus.start = 1'b0; bus.len = '0;
    for (int i = 0; i < DEPTH; i++) begin ref_a[i] = 0; ref_b[i] = 0; end

    // start held during reset must not launch anything
    reset = 1'b1;
    bus.start = 1'b1;
    bus.len = (AW+1)'(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_busy", longint'(bus.busy), 0);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet("idle");
    end

    load_basic();
    run_vec(3, 0, 0, 1, 0, 0, 0, 0);
    check_val("f_basic", acc, -5);
    run_vec(3, 0, 1, 0, 0, 0, 0, 0);
    check_val("f_inject", acc, -5);
    run_vec(3, 0, 0, 0, 0, 0, 0, 0);
    check_val("f_rerun", acc, -5);

    write_pair(0, -8192, -8192);
    write_pair(1, -8192, -8192);
    run_vec(2, 0, 0, 0, 0, 0, 0, 0);
    check_val("f_negmax", acc, 134217728);
    write_pair(0, 8191, -8192);
    run_vec(1, 0, 0, 0, 0, 0, 0, 0);
    check_val("f_mixmax", acc, -67100672);

    run_vec(0, 0, 0, 0, 0, 0, 0, 0);
    check_val("f_len0", acc, 0);

    for (int i = 0; i < DEPTH; i++) write_pair(i, rnd_op(), rnd_op());
    run_vec(31, 0, 0, 0, 0, 0, 0, 0);

    load_basic();
    run_vec(3, 3, 0, 0, 0, 0, 0, 0);
    run_vec(3, 0, 0, 0, 0, 0, 0, 0);
    check_val("f_after_abort", acc, -5);

    // write and start on the same cycle: streaming sees the new pair
    run_vec(2, 0, 0, 0, 1, 1, rnd_op(), rnd_op());

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) write_pair(i, rnd_op(), rnd_op());
      run_vec(int'($urandom_range(0, 31)), 0, 0, r % 2, r % 3 == 0,
              int'($urandom_range(0, DEPTH - 1)), rnd_op(), rnd_op());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
